// File: rtl/vec_exec_pkg.sv
// Shared types for the vector execution pipe.
// Declares the op/SEW encodings, the FSM state type, the captured-control
// payload and the legality check used at accept.
package vec_exec_pkg;

  localparam int unsigned DEF_VLEN = 512;
  localparam int unsigned ELEM32   = DEF_VLEN / 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SLL = 3'd1,
    OP_SRL = 3'd2,
    OP_MUL = 3'd3,
    OP_SRA = 3'd4
  } vec_op_e;

  typedef enum logic [1:0] {
    SEW8    = 2'd0,
    SEW16   = 2'd1,
    SEW32   = 2'd2,
    SEW_ILL = 2'd3
  } vec_sew_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MUL_WAIT = 2'd2,
    S_DONE     = 2'd3
  } exec_state_e;

  // Add/shift controls captured at accept
  typedef struct packed {
    vec_op_e  op;
    vec_sew_e sew;
    logic     sub;
    logic     rev;
  } vec_ctrl_t;

  // Op and SEW are both inside their defined encodings
  function automatic logic ctrl_legal(input logic [2:0] op, input logic [1:0] sew);
    return (op <= 3'd4) && (sew != 2'd3);
  endfunction

endpackage

// File: rtl/vec_simd_mul.sv
// Per-lane SIMD multiplier with a LAT-deep free-running result pipeline.
// Ports: clk; a, b operands (VLEN); sew lane width; signed_mode selects
// signed x signed; mul_high selects upper SEW bits of each product;
// result valid LAT cycles after operands are presented.
module vec_simd_mul
  import vec_exec_pkg::*;
#(
  parameter int unsigned VLEN = DEF_VLEN,
  parameter int unsigned LAT  = 4
) (
  input  logic            clk,
  input  logic [VLEN-1:0] a,
  input  logic [VLEN-1:0] b,
  input  vec_sew_e        sew,
  input  logic            signed_mode,
  input  logic            mul_high,
  output logic [VLEN-1:0] result
);

  localparam int unsigned N_WORDS = VLEN / 32;

  logic [VLEN-1:0] prod_c;
  logic [VLEN-1:0] pipe_q [LAT];

  // Extend one lane to 64 bits, multiply, pick the requested half.
  // The 2*SEW-bit product always fits in 64 bits, so modular 64-bit math is exact.
  function automatic logic [31:0] mul_lane(input logic [31:0] x, input logic [31:0] y,
                                           input vec_sew_e s, input logic sgn,
                                           input logic hi);
    logic [63:0] xe, ye, p;
    logic [31:0] r;
    case (s)
      SEW8: begin
        xe = {{56{sgn & x[7]}}, x[7:0]};
        ye = {{56{sgn & y[7]}}, y[7:0]};
      end
      SEW16: begin
        xe = {{48{sgn & x[15]}}, x[15:0]};
        ye = {{48{sgn & y[15]}}, y[15:0]};
      end
      default: begin
        xe = {{32{sgn & x[31]}}, x};
        ye = {{32{sgn & y[31]}}, y};
      end
    endcase
    p = xe * ye;
    case (s)
      SEW8:    r = hi ? {24'd0, p[15:8]}  : {24'd0, p[7:0]};
      SEW16:   r = hi ? {16'd0, p[31:16]} : {16'd0, p[15:0]};
      default: r = hi ? p[63:32] : p[31:0];
    endcase
    return r;
  endfunction

  // Lane products across every 32-bit word
  always_comb begin
    prod_c = '0;
    for (int unsigned w = 0; w < N_WORDS; w++) begin
      case (sew)
        SEW8:
          for (int unsigned l = 0; l < 4; l++)
            prod_c[32*w+8*l +: 8] = 8'(mul_lane({24'd0, a[32*w+8*l +: 8]},
                                                {24'd0, b[32*w+8*l +: 8]},
                                                sew, signed_mode, mul_high));
        SEW16:
          for (int unsigned l = 0; l < 2; l++)
            prod_c[32*w+16*l +: 16] = 16'(mul_lane({16'd0, a[32*w+16*l +: 16]},
                                                   {16'd0, b[32*w+16*l +: 16]},
                                                   sew, signed_mode, mul_high));
        default:
          prod_c[32*w +: 32] = mul_lane(a[32*w +: 32], b[32*w +: 32],
                                        sew, signed_mode, mul_high);
      endcase
    end
  end

  // Result delay line; the controlling FSM knows when the entry is valid
  always_ff @(posedge clk) begin
    pipe_q[0] <= prod_c;
    for (int k = 1; k < int'(LAT); k++) pipe_q[k] <= pipe_q[k-1];
  end

  assign result = pipe_q[LAT-1];

endmodule

// File: rtl/vector_exec_pipe.sv
// Handshaked vector execution unit: per-element add/sub/rsub, shifts and
// multiply over a VLEN-bit slice at SEW 8/16/32, one operation in flight.
// Ports: clk, reset (sync, active-low); in_valid/in_ready with operands
// in_data_1 (vs2), in_data_2 (vs1/rs1) and controls in_op, in_sew, in_sub,
// in_rev, in_signed, in_mul_high; out_valid/out_ready with out_result and
// out_err (illegal op/SEW); busy while an operation is held.
module vector_exec_pipe
  import vec_exec_pkg::*;
#(
  parameter int unsigned VLEN    = DEF_VLEN,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] in_data_1,
  input  logic [VLEN-1:0] in_data_2,
  input  logic [2:0]      in_op,
  input  logic [1:0]      in_sew,
  input  logic            in_sub,
  input  logic            in_rev,
  input  logic            in_signed,
  input  logic            in_mul_high,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] out_result,
  output logic            out_err,
  output logic            busy
);

  localparam int unsigned N_WORDS = VLEN / 32;
  localparam int unsigned CNT_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  exec_state_e     state;
  logic [CNT_W-1:0] cnt;
  vec_ctrl_t       ctrl_q;
  logic            legal_q;
  logic            legal_c;
  logic [VLEN-1:0] a_q, b_q;
  logic [VLEN-1:0] alu_res_c;
  logic [VLEN-1:0] mul_res;

  assign legal_c = ctrl_legal(in_op, in_sew);

  // One lane of add/shift; x and y arrive zero-extended from the lane width
  function automatic logic [31:0] alu_lane(input logic [31:0] x, input logic [31:0] y,
                                           input vec_sew_e s, input vec_op_e op,
                                           input logic sub, input logic rev);
    logic [31:0] xs;
    logic [4:0]  sh;
    logic [31:0] r;
    case (s)
      SEW8:    begin xs = {{24{x[7]}}, x[7:0]};   sh = {2'b00, y[2:0]}; end
      SEW16:   begin xs = {{16{x[15]}}, x[15:0]}; sh = {1'b0, y[3:0]};  end
      default: begin xs = x;                      sh = y[4:0];          end
    endcase
    case (op)
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = 32'($signed(xs) >>> sh);
      default: r = !sub ? (x + y) : (rev ? (y - x) : (x - y));
    endcase
    return r;
  endfunction

  // Split a 32-bit word into lanes; truncation drops carries at lane edges
  function automatic logic [31:0] alu_word(input logic [31:0] a, input logic [31:0] b,
                                           input vec_ctrl_t c);
    logic [31:0] r;
    r = '0;
    case (c.sew)
      SEW8:
        for (int unsigned l = 0; l < 4; l++)
          r[8*l +: 8] = 8'(alu_lane({24'd0, a[8*l +: 8]}, {24'd0, b[8*l +: 8]},
                                    c.sew, c.op, c.sub, c.rev));
      SEW16:
        for (int unsigned l = 0; l < 2; l++)
          r[16*l +: 16] = 16'(alu_lane({16'd0, a[16*l +: 16]}, {16'd0, b[16*l +: 16]},
                                       c.sew, c.op, c.sub, c.rev));
      default: r = alu_lane(a, b, c.sew, c.op, c.sub, c.rev);
    endcase
    return r;
  endfunction

  always_comb begin
    alu_res_c = '0;
    for (int unsigned w = 0; w < N_WORDS; w++)
      alu_res_c[32*w +: 32] = alu_word(a_q[32*w +: 32], b_q[32*w +: 32], ctrl_q);
  end

  // Multiplier samples the live inputs every cycle; the accept-cycle sample
  // emerges after MUL_LAT edges, exactly when cnt reaches zero.
  vec_simd_mul #(
    .VLEN (VLEN),
    .LAT  (MUL_LAT)
  ) u_mul (
    .clk         (clk),
    .a           (in_data_1),
    .b           (in_data_2),
    .sew         (vec_sew_e'(in_sew)),
    .signed_mode (in_signed),
    .mul_high    (in_mul_high),
    .result      (mul_res)
  );

  // Operand capture at accept
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      a_q     <= in_data_1;
      b_q     <= in_data_2;
      ctrl_q  <= '{op: vec_op_e'(in_op), sew: vec_sew_e'(in_sew), sub: in_sub, rev: in_rev};
      legal_q <= legal_c;
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (legal_c && in_op == OP_MUL) begin
              state <= S_MUL_WAIT;
              cnt   <= CNT_W'(MUL_LAT - 1);
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          out_result <= legal_q ? alu_res_c : '0;
          out_err    <= !legal_q;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_MUL_WAIT: begin
          if (cnt == '0) begin
            out_result <= mul_res;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
